// File: rtl/dl_pkg.sv
// dl_pkg: shared types for the dl skid buffer
package dl_pkg;
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } dl_skid_state_t;
endpackage

// File: rtl/dl_skid_buf.sv
// dl_skid_buf: two-entry ready/valid skid buffer with registered in_ready and flush
module dl_skid_buf
  import dl_pkg::*;
#(
  parameter int                  NUM_BITS = 32,
  parameter logic [NUM_BITS-1:0] RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_data,
  output logic [1:0]          count
);
  dl_skid_state_t state, state_nxt;
  logic [NUM_BITS-1:0] main_q, skid_q, main_nxt;
  logic in_fire, out_fire, clear, state_en, main_en, skid_en;
  assign in_ready  = state != FULL;
  assign out_valid = state != EMPTY;
  assign out_data  = main_q;
  assign count     = state;
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign clear     = !rst_n | flush;
  always_comb begin
    state_nxt = state == EMPTY ? (in_fire ? ONE : EMPTY) :
                state == FULL  ? (out_fire ? ONE : FULL) :
                in_fire & !out_fire ? FULL :
                !in_fire & out_fire ? EMPTY : ONE;
    state_en  = state_nxt != state;
    main_en   = state == FULL ? out_fire : state == EMPTY ? in_fire : in_fire & out_fire;
    main_nxt  = state == FULL ? skid_q : in_data;
    skid_en   = state == ONE & in_fire & !out_fire;
  end
  always_ff @(posedge clk)
    if (clear) state <= EMPTY;
    else if (state_en) state <= state_nxt;
  always_ff @(posedge clk)
    if (clear) main_q <= RST_VAL;
    else if (main_en) main_q <= main_nxt;
  always_ff @(posedge clk)
    if (clear) skid_q <= RST_VAL;
    else if (skid_en) skid_q <= in_data;
endmodule

// File: tb/tb_dl_skid_buf.sv
// tb_dl_skid_buf: randomized and directed checks of dl_skid_buf against a queue model
module tb_dl_skid_buf;
  localparam int NB = 32;
  localparam logic [NB-1:0] RV = 32'hDEAD_BEEF;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [NB-1:0] in_data = '0, out_data;
  logic [1:0] count;
  logic [NB-1:0] q[$];
  int tests = 0, fails = 0;
  dl_skid_buf #(.NUM_BITS(NB), .RST_VAL(RV)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );
  always #5 clk = ~clk;
  task automatic cyc(input logic v, input logic [NB-1:0] d, input logic r, input logic f, input logic rn);
    bit ofire, ifire;
    in_valid = v; in_data = d; out_ready = r; flush = f; rst_n = rn;
    @(posedge clk);
    if (!rn || f) q.delete();
    else begin
      ofire = q.size() > 0 && r;
      ifire = v && q.size() < 2;
      if (ofire) void'(q.pop_front());
      if (ifire) q.push_back(d);
    end
    #1;
  endtask
  task automatic test_reset;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", count); end
    tests++; if (out_data !== RV) begin fails++; $display("FAIL reset_data got %h exp %h", out_data, RV); end
  endtask
  task automatic test_single;
    cyc(1, 32'hA5, 1, 0, 1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", out_valid); end
    tests++; if (out_data !== 32'hA5) begin fails++; $display("FAIL single_data got %h exp a5", out_data); end
    tests++; if (count !== 2'd1) begin fails++; $display("FAIL single_count got %0d exp 1", count); end
    cyc(0, 0, 1, 0, 1);
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL single_drain got %0d exp 0", count); end
  endtask
  task automatic test_stream;
    for (int i = 1; i <= 4; i++) begin
      cyc(1, NB'(i), 1, 0, 1);
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL stream_ready[%0d] got %b exp 1", i, in_ready); end
      tests++; if (out_valid !== 1'b1 || out_data !== NB'(i)) begin fails++; $display("FAIL stream_data[%0d] got %b/%h exp 1/%h", i, out_valid, out_data, i); end
    end
    cyc(0, 0, 1, 0, 1);
  endtask
  task automatic test_backpressure;
    cyc(1, 32'h10, 0, 0, 1);
    cyc(1, 32'h11, 0, 0, 1);
    tests++; if (count !== 2'd2 || in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got count %0d rdy %b exp 2/0", count, in_ready); end
    tests++; if (out_data !== 32'h10) begin fails++; $display("FAIL bp_head got %h exp 10", out_data); end
    cyc(0, 0, 1, 0, 1);
    tests++; if (out_data !== 32'h11 || in_ready !== 1'b1 || count !== 2'd1) begin fails++; $display("FAIL bp_second got %h rdy %b cnt %0d exp 11/1/1", out_data, in_ready, count); end
    cyc(0, 0, 1, 0, 1);
    tests++; if (count !== 2'd0) begin fails++; $display("FAIL bp_drain got %0d exp 0", count); end
  endtask
  task automatic test_full_hold;
    cyc(1, 32'h20, 0, 0, 1);
    cyc(1, 32'h21, 0, 0, 1);
    cyc(1, 32'h99, 0, 0, 1);
    cyc(1, 32'h99, 0, 0, 1);
    tests++; if (count !== 2'd2 || out_data !== 32'h20) begin fails++; $display("FAIL hold_full got cnt %0d data %h exp 2/20", count, out_data); end
    cyc(1, 32'h99, 1, 0, 1);
    tests++; if (count !== 2'd1 || out_data !== 32'h21) begin fails++; $display("FAIL hold_pop got cnt %0d data %h exp 1/21", count, out_data); end
    cyc(1, 32'h99, 1, 0, 1);
    tests++; if (count !== 2'd1 || out_data !== 32'h99) begin fails++; $display("FAIL hold_accept got cnt %0d data %h exp 1/99", count, out_data); end
    cyc(0, 0, 1, 0, 1);
    tests++; if (count !== 2'd0 || out_valid !== 1'b0) begin fails++; $display("FAIL hold_once got cnt %0d vld %b exp 0/0", count, out_valid); end
  endtask
  task automatic test_flush;
    cyc(1, 32'h30, 0, 0, 1);
    cyc(1, 32'h31, 0, 0, 1);
    cyc(1, 32'h32, 1, 1, 1);
    tests++; if (count !== 2'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin fails++; $display("FAIL flush_state got cnt %0d vld %b rdy %b exp 0/0/1", count, out_valid, in_ready); end
    tests++; if (out_data !== RV) begin fails++; $display("FAIL flush_data got %h exp %h", out_data, RV); end
    cyc(0, 0, 1, 0, 1);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost got %b exp 0", out_valid); end
  endtask
  task automatic test_reset_mid;
    cyc(1, 32'h40, 0, 0, 1);
    cyc(1, 32'h41, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    tests++; if (count !== 2'd0 || out_valid !== 1'b0 || out_data !== RV) begin fails++; $display("FAIL rstmid_state got cnt %0d vld %b data %h exp 0/0/%h", count, out_valid, out_data, RV); end
    cyc(1, 32'h42, 1, 0, 1);
    tests++; if (count !== 2'd1 || out_data !== 32'h42) begin fails++; $display("FAIL rstmid_accept got cnt %0d data %h exp 1/42", count, out_data); end
    cyc(0, 0, 1, 0, 1);
  endtask
  task automatic test_random;
    for (int i = 0; i < 3000; i++) begin
      tests++; if (in_ready !== 1'(q.size() < 2)) begin fails++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, in_ready, q.size() < 2); end
      tests++; if (out_valid !== 1'(q.size() > 0)) begin fails++; $display("FAIL rnd_valid[%0d] got %b exp %b", i, out_valid, q.size() > 0); end
      tests++; if (count !== 2'(q.size())) begin fails++; $display("FAIL rnd_count[%0d] got %0d exp %0d", i, count, q.size()); end
      if (q.size() > 0) begin
        tests++; if (out_data !== q[0]) begin fails++; $display("FAIL rnd_data[%0d] got %h exp %h", i, out_data, q[0]); end
      end
      cyc(1'($urandom_range(0, 2) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
          1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 99) != 0));
    end
  endtask
  initial begin
    test_reset;
    test_single;
    test_stream;
    test_backpressure;
    test_full_hold;
    test_flush;
    test_reset_mid;
    test_random;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dl_skid_buf.md
DL_SKID_BUF -- requirements
Module: dl_skid_buf

Interface
REQ-001 The block SHALL have parameter NUM_BITS, default 32, giving the payload width in bits.
REQ-002 The block SHALL have parameter RST_VAL, default 0, giving the value loaded into both payload registers on reset and flush.
REQ-003 The block SHALL have port clk, input, 1 bit: the clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port flush, input, 1 bit: synchronous discard of all held entries.
REQ-006 The block SHALL have port in_valid, input, 1 bit: the upstream presents data.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the buffer can accept data this cycle.
REQ-008 The block SHALL have port in_data, input, NUM_BITS bits: the upstream payload.
REQ-009 The block SHALL have port out_valid, output, 1 bit: out_data is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the downstream accepts data this cycle.
REQ-011 The block SHALL have port out_data, output, NUM_BITS bits: the downstream payload.
REQ-012 The block SHALL have port count, output, 2 bits: the current occupancy, 0 to 2.

Function
REQ-013 The block SHALL hold two entries: MAIN, which drives out_data, and SKID, the overflow entry.
REQ-014 The state machine SHALL have three states: EMPTY (count 0), ONE (MAIN valid, count 1) and FULL (MAIN and SKID valid, count 2).
REQ-015 An input fire SHALL be in_valid and in_ready in the same cycle; an output fire SHALL be out_valid and out_ready in the same cycle.
REQ-016 in_ready SHALL be registered and SHALL be 1 exactly when the state is not FULL; in_ready SHALL NOT depend combinationally on out_ready.
REQ-017 out_valid SHALL be 1 exactly when the state is ONE or FULL, and out_data SHALL always equal MAIN.
REQ-018 From EMPTY, an input fire SHALL load MAIN with in_data and move to ONE; otherwise the state SHALL stay EMPTY.
REQ-019 From ONE, simultaneous input and output fires SHALL load MAIN with in_data and stay in ONE, sustaining 1 transfer per cycle.
REQ-020 From ONE, an input fire alone SHALL load SKID with in_data and move to FULL.
REQ-021 From ONE, an output fire alone SHALL move to EMPTY.
REQ-022 From ONE, with no fire, the state SHALL stay ONE.
REQ-023 In FULL, no input SHALL be accepted; an output fire SHALL copy SKID into MAIN and move to ONE; otherwise the state SHALL stay FULL.
REQ-024 Latency SHALL be 1 cycle: data accepted at edge N SHALL appear on out_data with out_valid=1 in cycle N+1 or later.
REQ-025 Data SHALL leave in acceptance order, with no loss and no duplication.
REQ-026 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 flush=1 SHALL force EMPTY at the next edge, load RST_VAL into MAIN and SKID, and discard any input or output fire in that cycle.
REQ-028 flush SHALL take priority over handshake, and rst_n SHALL take priority over flush.
REQ-029 Payload registers SHALL update only on the loads listed above and SHALL otherwise hold their value.

Reset
REQ-030 While rst_n=0 at a rising edge, the next state SHALL be EMPTY: in_ready=1, out_valid=0, count=0, and MAIN and SKID equal to RST_VAL.
REQ-031 Reset asserted mid-operation SHALL drop all held entries without emitting them, and the block SHALL accept data on the first cycle after rst_n returns to 1.

Structure
REQ-032 The state encoding (EMPTY=0, ONE=1, FULL=2, 2 bits) SHALL be defined in the shared package dl_pkg as dl_skid_state_t.
REQ-033 count SHALL be derived directly from the state encoding.
REQ-034 The block SHALL be flat, with no sub-module; the MAIN and SKID payload registers and the state register SHALL each be a plain register with enable and synchronous reset.

Verification
REQ-035 Reset, then in_valid=1 with in_data=0xA5 and out_ready=1 -> out_valid=1 and out_data=0xA5 the next cycle, count=1.
REQ-036 Streaming 0x1,0x2,0x3,0x4 on consecutive cycles with out_ready held at 1 -> outputs 0x1..0x4 on consecutive cycles, in_ready stays 1.
REQ-037 out_ready=0 while 0x10 then 0x11 are sent -> count=2, in_ready=0, out_data=0x10; then out_ready=1 -> 0x10 then 0x11 emitted, in_ready=1 one cycle after the first output fire.
REQ-038 In FULL with in_valid=1 and in_data=0x99 held -> 0x99 is not accepted until in_ready=1, is emitted exactly once, and comes after the held entries.
REQ-039 flush=1 in FULL with in_valid=1 -> next cycle count=0, out_valid=0, in_ready=1, and the flush-cycle input is never emitted.
REQ-040 rst_n=0 for one cycle in FULL -> EMPTY the next cycle, out_data=RST_VAL, and no held data appears afterwards.
